// File: rtl/wb_stage_pkg.sv
// Shared widths, defaults and source-select encoding for the writeback stage.
package wb_stage_pkg;

   localparam int unsigned XLEN           = 64;
   localparam int unsigned INST_LEN       = 32;
   localparam int unsigned REG_IDX_W      = 5;
   localparam int unsigned DIV_FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_MEM  = 2'd1,
      WB_SRC_DIV  = 2'd2
   } wb_src_e;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM and divider result inputs, regfile write port outputs.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_stage_if #(
   parameter int unsigned XLEN     = wb_stage_pkg::XLEN,
   parameter int unsigned INST_LEN = wb_stage_pkg::INST_LEN
);
   import wb_stage_pkg::*;

   logic                 mem_valid_i;
   logic                 mem_ready_o;
   logic                 mem_wen_i;
   logic [REG_IDX_W-1:0] mem_rd_i;
   logic [XLEN-1:0]      mem_data_i;
   logic [XLEN-1:0]      mem_pc_i;
   logic [INST_LEN-1:0]  mem_instr_i;

   logic                 div_valid_i;
   logic                 div_ready_o;
   logic [REG_IDX_W-1:0] div_rd_i;
   logic [XLEN-1:0]      div_data_i;
   logic [XLEN-1:0]      div_pc_i;
   logic [INST_LEN-1:0]  div_instr_i;

   logic                 wb_wren_o;
   logic [REG_IDX_W-1:0] wb_rdid_o;
   logic [XLEN-1:0]      wb_data_o;
   logic [XLEN-1:0]      pc_wb_o;
   logic [INST_LEN-1:0]  instr_wb_o;
   logic                 commit_o;

`ifdef WB_FWD_EN
   logic [REG_IDX_W-1:0] fwd_rs1_idx_i;
   logic [REG_IDX_W-1:0] fwd_rs2_idx_i;
   logic                 fwd_rs1_hit_o;
   logic                 fwd_rs2_hit_o;
   logic [XLEN-1:0]      fwd_data_o;
   logic [XLEN-1:0]      fwd_rs2_data_o;
`endif

   modport slave (
      input  mem_valid_i, mem_wen_i, mem_rd_i, mem_data_i, mem_pc_i, mem_instr_i,
      input  div_valid_i, div_rd_i, div_data_i, div_pc_i, div_instr_i,
`ifdef WB_FWD_EN
      input  fwd_rs1_idx_i, fwd_rs2_idx_i,
      output fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_data_o, fwd_rs2_data_o,
`endif
      output mem_ready_o, div_ready_o,
      output wb_wren_o, wb_rdid_o, wb_data_o, pc_wb_o, instr_wb_o, commit_o
   );

   modport master (
      output mem_valid_i, mem_wen_i, mem_rd_i, mem_data_i, mem_pc_i, mem_instr_i,
      output div_valid_i, div_rd_i, div_data_i, div_pc_i, div_instr_i,
`ifdef WB_FWD_EN
      output fwd_rs1_idx_i, fwd_rs2_idx_i,
      input  fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_data_o, fwd_rs2_data_o,
`endif
      input  mem_ready_o, div_ready_o,
      input  wb_wren_o, wb_rdid_o, wb_data_o, pc_wb_o, instr_wb_o, commit_o
   );

endinterface

// File: rtl/wb_div_fifo.sv
// Synchronous FIFO buffering divider results; caller guarantees no push when
// full and no pop when empty.
module wb_div_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr] <= wdata;
   end

   assign rdata = mem_q[rd_ptr];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges in-order MEM results and buffered divider results
// onto the single regfile write port. Optional forwarding under WB_FWD_EN.
module wb_stage #(
   parameter int unsigned XLEN           = wb_stage_pkg::XLEN,
   parameter int unsigned INST_LEN       = wb_stage_pkg::INST_LEN,
   parameter int unsigned DIV_FIFO_DEPTH = wb_stage_pkg::DIV_FIFO_DEPTH
) (
   input logic       clk,
   input logic       rst_n,
   wb_stage_if.slave bus
);
   import wb_stage_pkg::*;

   localparam int unsigned CNT_W = $clog2(DIV_FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
      logic [XLEN-1:0]      pc;
      logic [INST_LEN-1:0]  instr;
   } div_entry_t;

   div_entry_t           push_entry;
   div_entry_t           head;
   logic [CNT_W-1:0]     count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   wb_src_e              sel;
   logic                 sel_wen;
   logic [REG_IDX_W-1:0] sel_rd;
   logic [XLEN-1:0]      sel_data;
   logic [XLEN-1:0]      sel_pc;
   logic [INST_LEN-1:0]  sel_instr;

   assign push_entry = '{rd: bus.div_rd_i, data: bus.div_data_i,
                         pc: bus.div_pc_i, instr: bus.div_instr_i};

   assign fifo_full       = (count == CNT_W'(DIV_FIFO_DEPTH));
   assign fifo_empty      = (count == '0);
   assign bus.div_ready_o = !fifo_full;
   assign bus.mem_ready_o = !fifo_full;
   assign push            = bus.div_valid_i && !fifo_full;
   assign pop             = (sel == WB_SRC_DIV);

   wb_div_fifo #(
      .DEPTH (DIV_FIFO_DEPTH),
      .W     ($bits(div_entry_t))
   ) u_div_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (head),
      .count (count)
   );

   // A full FIFO takes priority so the divider can never stall indefinitely.
   always_comb begin
      sel = WB_SRC_NONE;
      if (fifo_full)             sel = WB_SRC_DIV;
      else if (bus.mem_valid_i)  sel = WB_SRC_MEM;
      else if (!fifo_empty)      sel = WB_SRC_DIV;
   end

   always_comb begin
      sel_wen   = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      sel_pc    = '0;
      sel_instr = '0;
      case (sel)
         WB_SRC_MEM: begin
            sel_wen   = bus.mem_wen_i;
            sel_rd    = bus.mem_rd_i;
            sel_data  = bus.mem_data_i;
            sel_pc    = bus.mem_pc_i;
            sel_instr = bus.mem_instr_i;
         end
         WB_SRC_DIV: begin
            sel_wen   = 1'b1;
            sel_rd    = head.rd;
            sel_data  = head.data;
            sel_pc    = head.pc;
            sel_instr = head.instr;
         end
         default: ;
      endcase
   end

   // Payload registers hold their value on idle cycles; x0 writes still commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.wb_wren_o  <= 1'b0;
         bus.wb_rdid_o  <= '0;
         bus.wb_data_o  <= '0;
         bus.pc_wb_o    <= '0;
         bus.instr_wb_o <= '0;
         bus.commit_o   <= 1'b0;
      end else begin
         bus.wb_wren_o <= sel_wen && (sel_rd != '0);
         bus.commit_o  <= (sel != WB_SRC_NONE);
         if (sel != WB_SRC_NONE) begin
            bus.wb_rdid_o  <= sel_rd;
            bus.wb_data_o  <= sel_data;
            bus.pc_wb_o    <= sel_pc;
            bus.instr_wb_o <= sel_instr;
         end
      end
   end

`ifdef WB_FWD_EN
   assign bus.fwd_rs1_hit_o  = bus.wb_wren_o && (bus.wb_rdid_o == bus.fwd_rs1_idx_i)
                               && (bus.fwd_rs1_idx_i != '0);
   assign bus.fwd_rs2_hit_o  = bus.wb_wren_o && (bus.wb_rdid_o == bus.fwd_rs2_idx_i)
                               && (bus.fwd_rs2_idx_i != '0);
   assign bus.fwd_data_o     = bus.wb_data_o;
   assign bus.fwd_rs2_data_o = bus.wb_data_o;
`endif

endmodule
